// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial link blocks.
package serial_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitReady,
    StDrive,
    StGap
  } ser_state_t;

  localparam int unsigned WORD_WIDTH_D  = 8;
  localparam int unsigned HIGH_CYCLES_D = 10;
  localparam int unsigned LOW_CYCLES_D  = 10;

  // A one-cycle phase still needs a one-bit counter.
  function automatic int unsigned phase_width(input int unsigned high, input int unsigned low);
    int unsigned m;
    m = (high > low) ? high : low;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that saturates at zero and flags it.
module phase_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/byte_serializer.sv
// MSB-first parallel-to-serial transmitter with a strobed bit output that
// stalls at bit boundaries while the downstream receiver is not ready.
module byte_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = WORD_WIDTH_D,
  parameter int unsigned HIGH_CYCLES = HIGH_CYCLES_D,
  parameter int unsigned LOW_CYCLES  = LOW_CYCLES_D
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] byte_in,
  input  logic                  byte_valid_in,
  output logic                  byte_ready_out,
  input  logic                  ready_in,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  busy_out
);

  localparam int unsigned PhaseW  = phase_width(HIGH_CYCLES, LOW_CYCLES);
  localparam int unsigned BitCntW = $clog2(WORD_WIDTH + 1);

  localparam logic [PhaseW-1:0]  HighLoad = PhaseW'(HIGH_CYCLES - 1);
  localparam logic [PhaseW-1:0]  LowLoad  = PhaseW'(LOW_CYCLES - 1);
  localparam logic [BitCntW-1:0] BitsFull = BitCntW'(WORD_WIDTH);

  ser_state_t            state_q;
  logic [WORD_WIDTH-1:0] shift_q;
  logic [WORD_WIDTH-1:0] shift_next;
  logic [BitCntW-1:0]    bit_cnt_q;
  logic                  ready_q, data_q, write_q, busy_q;

  logic                  phase_load;
  logic [PhaseW-1:0]     phase_value;
  logic                  phase_zero;
  logic                  last_bit;

  assign shift_next = shift_q << 1;
  assign last_bit   = (bit_cnt_q == BitCntW'(1));

  // Counter is reloaded on every transition into DRIVE or GAP.
  always_comb begin
    phase_load  = 1'b0;
    phase_value = HighLoad;
    case (state_q)
      StWaitReady: phase_load = ready_in;
      StDrive: begin
        phase_load  = phase_zero;
        phase_value = LowLoad;
      end
      StGap:   phase_load = phase_zero && !last_bit && ready_in;
      default: phase_load = 1'b0;
    endcase
  end

  phase_counter #(
    .Width (PhaseW)
  ) u_phase_counter (
    .clk_i   (clock),
    .rst_ni  (rst),
    .load_i  (phase_load),
    .value_i (phase_value),
    .zero_o  (phase_zero)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ready_q   <= 1'b1;
      data_q    <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (byte_valid_in) begin
            shift_q   <= byte_in;
            bit_cnt_q <= BitsFull;
            data_q    <= byte_in[WORD_WIDTH-1];
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StWaitReady;
          end
        end
        StWaitReady: begin
          if (ready_in) begin
            write_q <= 1'b1;
            state_q <= StDrive;
          end
        end
        StDrive: begin
          if (phase_zero) begin
            write_q <= 1'b0;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (phase_zero) begin
            shift_q   <= shift_next;
            bit_cnt_q <= bit_cnt_q - 1'b1;
            if (last_bit) begin
              data_q  <= 1'b0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              data_q <= shift_next[WORD_WIDTH-1];
              if (ready_in) begin
                write_q <= 1'b1;
                state_q <= StDrive;
              end else begin
                state_q <= StWaitReady;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign byte_ready_out = ready_q;
  assign data_out       = data_q;
  assign write_out      = write_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: default timing plus a 1/1 strobe corner.
module tb_byte_serializer;

  logic       clock = 1'b0;
  logic       rst;
  logic [7:0] byte_in = '0;
  logic       byte_valid_in = 1'b0;
  logic       ready_in = 1'b1;
  logic       byte_ready_out, data_out, write_out, busy_out;

  logic [7:0] byte_in2 = '0;
  logic       byte_valid_in2 = 1'b0;
  logic       ready_in2 = 1'b1;
  logic       byte_ready_out2, data_out2, write_out2, busy_out2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  byte_serializer u_dut (
    .clock          (clock),
    .rst            (rst),
    .byte_in        (byte_in),
    .byte_valid_in  (byte_valid_in),
    .byte_ready_out (byte_ready_out),
    .ready_in       (ready_in),
    .data_out       (data_out),
    .write_out      (write_out),
    .busy_out       (busy_out)
  );

  byte_serializer #(
    .WORD_WIDTH  (8),
    .HIGH_CYCLES (1),
    .LOW_CYCLES  (1)
  ) u_dut_fast (
    .clock          (clock),
    .rst            (rst),
    .byte_in        (byte_in2),
    .byte_valid_in  (byte_valid_in2),
    .byte_ready_out (byte_ready_out2),
    .ready_in       (ready_in2),
    .data_out       (data_out2),
    .write_out      (write_out2),
    .busy_out       (busy_out2)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Strobe monitor: rise cycle, sampled bit and high length of each strobe.
  int   rise_q[$];
  logic bit_q[$];
  int   hlen_q[$];
  int   unstable = 0;
  int   last_rise = 0;
  logic wr_prev = 1'b0;

  always @(negedge clock) begin
    if (write_out && !wr_prev) begin
      rise_q.push_back(cyc);
      bit_q.push_back(data_out);
      last_rise = cyc;
    end else if (write_out && wr_prev && bit_q.size() > 0 && data_out !== bit_q[$]) begin
      unstable++;
    end
    if (!write_out && wr_prev) hlen_q.push_back(cyc - last_rise);
    wr_prev = write_out;
  end

  // Acceptance monitor: edge number and word of each handshake.
  int         acc_q[$];
  logic [7:0] accd_q[$];

  always @(posedge clock) begin
    if (rst && byte_valid_in && byte_ready_out) begin
      acc_q.push_back(cyc + 1);
      accd_q.push_back(byte_in);
    end
  end

  task automatic clear_logs();
    rise_q.delete();
    bit_q.delete();
    hlen_q.delete();
    acc_q.delete();
    accd_q.delete();
    unstable = 0;
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      #1;
      if (hlen_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      #1;
      if (busy_out === 1'b0 && byte_ready_out === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (byte_ready_out !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready: got %b want 1", byte_ready_out);
    end
    n_checks++;
    if (write_out !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_write: got %b want 0", write_out);
    end
    n_checks++;
    if (data_out !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_data: got %b want 0", data_out);
    end
    n_checks++;
    if (busy_out !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_busy: got %b want 0", busy_out);
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] exp;
    int e0, t_idle;
    bit ok;
    exp = 8'h80;
    clear_logs();
    @(negedge clock);
    byte_in = exp;
    byte_valid_in = 1'b1;
    @(negedge clock);
    #1;
    byte_valid_in = 1'b0;
    e0 = cyc;
    n_checks++;
    if (acc_q.size() !== 1 || (acc_q.size() > 0 && acc_q[0] !== e0)) begin
      n_errors++;
      $display("FAIL single_accept: got %0d accepts want 1 at cycle %0d", acc_q.size(), e0);
    end
    n_checks++;
    if (byte_ready_out !== 1'b0 || busy_out !== 1'b1) begin
      n_errors++;
      $display("FAIL single_busy: got ready=%b busy=%b want 0/1", byte_ready_out, busy_out);
    end
    wait_strobes(8, 400, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL single_strobes: got %0d strobes want 8", hlen_q.size());
      return;
    end
    wait_idle(100, ok, t_idle);
    n_checks++;
    if (!ok || t_idle !== e0 + 1 + 160) begin
      n_errors++;
      $display("FAIL single_idle: got cycle %0d want %0d", t_idle, e0 + 161);
    end
    n_checks++;
    if (rise_q[0] !== e0 + 1) begin
      n_errors++;
      $display("FAIL single_first_rise: got %0d want %0d", rise_q[0], e0 + 1);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bit_q[i] !== exp[7-i] || hlen_q[i] !== 10) begin
        n_errors++;
        $display("FAIL single_bit%0d: got bit=%b high=%0d want bit=%b high=10",
                 i, bit_q[i], hlen_q[i], exp[7-i]);
      end
      if (i < 7) begin
        n_checks++;
        if (rise_q[i+1] - rise_q[i] !== 20) begin
          n_errors++;
          $display("FAIL single_period%0d: got %0d want 20", i, rise_q[i+1] - rise_q[i]);
        end
      end
    end
    n_checks++;
    if (unstable !== 0) begin
      n_errors++;
      $display("FAIL single_stable: got %0d data changes while high want 0", unstable);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp;
    int e0, t_idle;
    bit ok;
    exp = 8'hA5;
    clear_logs();
    @(negedge clock);
    byte_in = exp;
    byte_valid_in = 1'b1;
    @(negedge clock);
    #1;
    byte_valid_in = 1'b0;
    e0 = cyc;
    wait_strobes(3, 200, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL stall_pre: got %0d strobes want 3", hlen_q.size());
      return;
    end
    // Hold ready low across the last gap edge and 49 following edges.
    repeat (9) @(negedge clock);
    ready_in = 1'b0;
    repeat (50) @(negedge clock);
    ready_in = 1'b1;
    wait_strobes(8, 400, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL stall_strobes: got %0d strobes want 8", hlen_q.size());
      return;
    end
    wait_idle(100, ok, t_idle);
    n_checks++;
    if (!ok || t_idle !== e0 + 1 + 160 + 50) begin
      n_errors++;
      $display("FAIL stall_idle: got cycle %0d want %0d", t_idle, e0 + 211);
    end
    n_checks++;
    if (rise_q[3] - rise_q[2] !== 70) begin
      n_errors++;
      $display("FAIL stall_delay: got period %0d want 70", rise_q[3] - rise_q[2]);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bit_q[i] !== exp[7-i] || hlen_q[i] !== 10) begin
        n_errors++;
        $display("FAIL stall_bit%0d: got bit=%b high=%0d want bit=%b high=10",
                 i, bit_q[i], hlen_q[i], exp[7-i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    int t_idle;
    bit ok;
    exp = 16'h8182;
    clear_logs();
    @(negedge clock);
    byte_in = 8'h81;
    byte_valid_in = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      if (acc_q.size() >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    byte_in = 8'h82;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL b2b_first: got no acceptance want one");
    end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      #1;
      if (acc_q.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    byte_valid_in = 1'b0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL b2b_second: got %0d acceptances want 2", acc_q.size());
      return;
    end
    wait_strobes(16, 400, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL b2b_strobes: got %0d strobes want 16", hlen_q.size());
      return;
    end
    wait_idle(100, ok, t_idle);
    n_checks++;
    if (acc_q.size() !== 2 || acc_q[1] - acc_q[0] !== 162) begin
      n_errors++;
      $display("FAIL b2b_gap: got %0d accepts spacing %0d want 2 spacing 162",
               acc_q.size(), acc_q[1] - acc_q[0]);
    end
    n_checks++;
    if (accd_q[0] !== 8'h81 || accd_q[1] !== 8'h82) begin
      n_errors++;
      $display("FAIL b2b_words: got %h %h want 81 82", accd_q[0], accd_q[1]);
    end
    n_checks++;
    if (rise_q[8] !== acc_q[1] + 1) begin
      n_errors++;
      $display("FAIL b2b_rise9: got %0d want %0d", rise_q[8], acc_q[1] + 1);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (bit_q[i] !== exp[15-i]) begin
        n_errors++;
        $display("FAIL b2b_bit%0d: got %b want %b", i, bit_q[i], exp[15-i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    int t_idle;
    bit ok;
    clear_logs();
    @(negedge clock);
    byte_in = 8'hF0;
    byte_valid_in = 1'b1;
    @(negedge clock);
    byte_valid_in = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #1;
      if (rise_q.size() >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL rstmid_pre: got %0d strobes want 5", rise_q.size());
      return;
    end
    repeat (3) @(negedge clock);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (write_out !== 1'b0 || busy_out !== 1'b0 || byte_ready_out !== 1'b1 ||
        data_out !== 1'b0) begin
      n_errors++;
      $display("FAIL rstmid_async: got write=%b busy=%b ready=%b data=%b want 0 0 1 0",
               write_out, busy_out, byte_ready_out, data_out);
    end
    repeat (5) @(negedge clock);
    rst = 1'b1;
    repeat (30) @(negedge clock);
    n_checks++;
    if (rise_q.size() !== 5) begin
      n_errors++;
      $display("FAIL rstmid_quiet: got %0d strobes want 5", rise_q.size());
    end
    // Second reset pulse, then present 0x3C together with release.
    rst = 1'b0;
    repeat (2) @(negedge clock);
    clear_logs();
    exp = 8'h3C;
    rst = 1'b1;
    byte_in = exp;
    byte_valid_in = 1'b1;
    @(negedge clock);
    #1;
    byte_valid_in = 1'b0;
    n_checks++;
    if (acc_q.size() !== 1 || (acc_q.size() > 0 && accd_q[0] !== exp)) begin
      n_errors++;
      $display("FAIL rstmid_accept: got %0d accepts want 1 of 3c on first edge", acc_q.size());
    end
    wait_strobes(8, 400, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL rstmid_strobes: got %0d strobes want 8", hlen_q.size());
      return;
    end
    wait_idle(100, ok, t_idle);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bit_q[i] !== exp[7-i] || hlen_q[i] !== 10) begin
        n_errors++;
        $display("FAIL rstmid_bit%0d: got bit=%b high=%0d want bit=%b high=10",
                 i, bit_q[i], hlen_q[i], exp[7-i]);
      end
    end
  endtask

  task automatic test_corner();
    logic exp_wr;
    @(negedge clock);
    byte_in2 = 8'hFF;
    byte_valid_in2 = 1'b1;
    @(negedge clock);
    #1;
    byte_valid_in2 = 1'b0;
    n_checks++;
    if (busy_out2 !== 1'b1 || byte_ready_out2 !== 1'b0) begin
      n_errors++;
      $display("FAIL corner_accept: got busy=%b ready=%b want 1/0", busy_out2, byte_ready_out2);
    end
    for (int j = 0; j < 18; j++) begin
      @(negedge clock);
      #1;
      exp_wr = (j < 16) && (j % 2 == 0);
      n_checks++;
      if (write_out2 !== exp_wr) begin
        n_errors++;
        $display("FAIL corner_write%0d: got %b want %b", j, write_out2, exp_wr);
      end
      if (j < 16) begin
        n_checks++;
        if (data_out2 !== 1'b1) begin
          n_errors++;
          $display("FAIL corner_data%0d: got %b want 1", j, data_out2);
        end
      end
      n_checks++;
      if (busy_out2 !== (j < 16)) begin
        n_errors++;
        $display("FAIL corner_busy%0d: got %b want %b", j, busy_out2, (j < 16));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_corner();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
